// File: rtl/ps2_pkg.sv
// Shared constants, prefix FSM encoding and event-word layout for the PS/2
// set-2 key event path.
package ps2_pkg;

    localparam logic [7:0] CODE_E0     = 8'hE0;
    localparam logic [7:0] CODE_E1     = 8'hE1;
    localparam logic [7:0] CODE_F0     = 8'hF0;

    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CTRL   = 8'h14;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    // Pause/Break sends E1 followed by seven more bytes that carry no key info.
    localparam logic [2:0] PAUSE_SKIP  = 3'd7;

    localparam int EV_RELEASE = 15;
    localparam int EV_EXT     = 14;
    localparam int EV_SHIFT   = 13;
    localparam int EV_CTRL    = 12;
    localparam int EV_CAPS    = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } prefix_state_t;

    // Keyboard housekeeping bytes (BAT result, acks, errors) that are not keys.
    function automatic logic is_ignored(input logic [7:0] code);
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// Combinational set-2 scan code to ASCII translation for letters, digits
// and a handful of control keys; extended codes never map.
module ps2_scancode_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] scan_code,
    input  logic       shift,
    input  logic       ctrl,
    input  logic       caps,
    input  logic       extended,
    output logic [7:0] ascii
);

    // Alphabet position 1..26, or 0 when the code is not a letter key.
    function automatic logic [4:0] letter_idx(input logic [7:0] code);
        case (code)
            8'h1C: return 5'd1;   8'h32: return 5'd2;   8'h21: return 5'd3;
            8'h23: return 5'd4;   8'h24: return 5'd5;   8'h2B: return 5'd6;
            8'h34: return 5'd7;   8'h33: return 5'd8;   8'h43: return 5'd9;
            8'h3B: return 5'd10;  8'h42: return 5'd11;  8'h4B: return 5'd12;
            8'h3A: return 5'd13;  8'h31: return 5'd14;  8'h44: return 5'd15;
            8'h4D: return 5'd16;  8'h15: return 5'd17;  8'h2D: return 5'd18;
            8'h1B: return 5'd19;  8'h2C: return 5'd20;  8'h3C: return 5'd21;
            8'h2A: return 5'd22;  8'h1D: return 5'd23;  8'h22: return 5'd24;
            8'h35: return 5'd25;  8'h1A: return 5'd26;
            default: return 5'd0;
        endcase
    endfunction

    logic [4:0] letter;

    always_comb begin
        ascii  = 8'h00;
        letter = letter_idx(scan_code);
        if (extended) begin
            ascii = 8'h00;
        end else if (letter != 5'd0) begin
            if (ctrl)
                ascii = {3'b000, letter};
            else if (shift ^ caps)
                ascii = {3'b010, letter};
            else
                ascii = {3'b011, letter};
        end else begin
            case (scan_code)
                8'h16: ascii = shift ? 8'h21 : 8'h31;
                8'h1E: ascii = shift ? 8'h40 : 8'h32;
                8'h26: ascii = shift ? 8'h23 : 8'h33;
                8'h25: ascii = shift ? 8'h24 : 8'h34;
                8'h2E: ascii = shift ? 8'h25 : 8'h35;
                8'h36: ascii = shift ? 8'h5E : 8'h36;
                8'h3D: ascii = shift ? 8'h26 : 8'h37;
                8'h3E: ascii = shift ? 8'h2A : 8'h38;
                8'h46: ascii = shift ? 8'h28 : 8'h39;
                8'h45: ascii = shift ? 8'h29 : 8'h30;
                8'h29: ascii = 8'h20;
                8'h5A: ascii = 8'h0D;
                8'h66: ascii = 8'h08;
                8'h0D: ascii = 8'h09;
                8'h76: ascii = 8'h1B;
                default: ascii = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_events.sv
// PS/2 set-2 byte stream to key press/release events with modifier state,
// queued in a small FIFO behind a valid/ack read port.
module ps2_key_events
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  scan_code,
    input  logic        scan_strobe,
    output logic        key_valid,
    output logic [15:0] key_data,
    output logic [7:0]  key_ascii,
    input  logic        key_ack,
    output logic        overflow,
    input  logic        overflow_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic          strobe_q;
    logic          byte_rise;
    prefix_state_t state, state_n;
    logic [2:0]    skip_cnt, skip_n;
    logic          lshift, lshift_n;
    logic          rshift, rshift_n;
    logic          ctrl, ctrl_n;
    logic          caps, caps_n;
    logic          caps_held, caps_held_n;
    logic          push, rel, ext;
    logic [15:0]   push_word;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full;
    logic          do_pop, do_push, drop;

    assign byte_rise = scan_strobe & ~strobe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q  <= 1'b0;
            state     <= ST_IDLE;
            skip_cnt  <= 3'd0;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            ctrl      <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
        end else begin
            strobe_q  <= scan_strobe;
            state     <= state_n;
            skip_cnt  <= skip_n;
            lshift    <= lshift_n;
            rshift    <= rshift_n;
            ctrl      <= ctrl_n;
            caps      <= caps_n;
            caps_held <= caps_held_n;
        end
    end

    always_comb begin
        state_n     = state;
        skip_n      = skip_cnt;
        lshift_n    = lshift;
        rshift_n    = rshift;
        ctrl_n      = ctrl;
        caps_n      = caps;
        caps_held_n = caps_held;
        push        = 1'b0;
        rel         = 1'b0;
        ext         = 1'b0;
        if (byte_rise) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == CODE_E0) begin
                        state_n = ST_EXT;
                    end else if (scan_code == CODE_F0) begin
                        state_n = ST_BRK;
                    end else if (scan_code == CODE_E1) begin
                        state_n = ST_PAUSE;
                        skip_n  = PAUSE_SKIP;
                    end else if (!is_ignored(scan_code)) begin
                        push = 1'b1;
                    end
                end
                ST_EXT: begin
                    state_n = ST_IDLE;
                    ext     = 1'b1;
                    if (scan_code == CODE_F0)
                        state_n = ST_EXT_BRK;
                    else if (scan_code != CODE_E0 && scan_code != CODE_E1 &&
                             scan_code != CODE_LSHIFT && scan_code != CODE_RSHIFT)
                        push = 1'b1;
                end
                ST_BRK: begin
                    state_n = ST_IDLE;
                    rel     = 1'b1;
                    push    = 1'b1;
                end
                ST_EXT_BRK: begin
                    state_n = ST_IDLE;
                    rel     = 1'b1;
                    ext     = 1'b1;
                    push    = (scan_code != CODE_LSHIFT && scan_code != CODE_RSHIFT);
                end
                ST_PAUSE: begin
                    skip_n = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1)
                        state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end

        // Modifiers update on the same byte whose event carries the new state.
        if (push) begin
            if (!ext && scan_code == CODE_LSHIFT) lshift_n = !rel;
            if (!ext && scan_code == CODE_RSHIFT) rshift_n = !rel;
            if (scan_code == CODE_CTRL)           ctrl_n   = !rel;
            if (!ext && scan_code == CODE_CAPS) begin
                if (rel) begin
                    caps_held_n = 1'b0;
                end else if (!caps_held) begin
                    caps_n      = ~caps;
                    caps_held_n = 1'b1;
                end
            end
        end

        push_word = {rel, ext, lshift_n | rshift_n, ctrl_n, caps_n, 3'b000, scan_code};
    end

    // Event FIFO: pointers carry one wrap bit so full and empty are distinct.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop     = key_ack & ~fifo_empty;
    assign do_push    = push & (~fifo_full | do_pop);
    assign drop       = push & fifo_full & ~do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= push_word;
    end

    assign key_valid = ~fifo_empty;
    assign key_data  = fifo_empty ? 16'h0000 : mem[rd_ptr[AW-1:0]];

    ps2_scancode_to_ascii u_ascii (
        .scan_code (key_data[7:0]),
        .shift     (key_data[EV_SHIFT]),
        .ctrl      (key_data[EV_CTRL]),
        .caps      (key_data[EV_CAPS]),
        .extended  (key_data[EV_EXT]),
        .ascii     (key_ascii)
    );

endmodule

// File: tb/tb_ps2_key_events.sv
// Self-checking bench for ps2_key_events: table-driven byte sequences with a
// scoreboard of expected events, plus FIFO overflow and reset sequences.
module tb_ps2_key_events;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic        scan_strobe = 1'b0;
    logic        key_valid;
    logic [15:0] key_data;
    logic [7:0]  key_ascii;
    logic        key_ack = 1'b0;
    logic        overflow;
    logic        overflow_clr = 1'b0;

    ps2_key_events #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_code    (scan_code),
        .scan_strobe  (scan_strobe),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .key_ascii    (key_ascii),
        .key_ack      (key_ack),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        bit          push;
        logic [15:0] word;
        logic [7:0]  ascii;
        bit          drain;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  ascii;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic add(input logic [7:0] c, input bit p, input logic [15:0] w,
                       input logic [7:0] a, input bit d);
        vec_t v;
        v.code = c; v.push = p; v.word = w; v.ascii = a; v.drain = d;
        vecs.push_back(v);
    endtask

    task automatic expect_event(input logic [15:0] w, input logic [7:0] a);
        exp_t e;
        e.word = w; e.ascii = a;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] c);
        @(negedge clk);
        scan_code   = c;
        scan_strobe = 1'b1;
        @(negedge clk);
        @(negedge clk);
        scan_strobe = 1'b0;
        @(negedge clk);
    endtask

    // Compare the head against the scoreboard front, then pop it.
    task automatic pop_check(input string name);
        exp_t e;
        e = sb.pop_front();
        @(negedge clk);
        check({name, " valid"}, {31'd0, key_valid}, 32'd1);
        check({name, " data"},  {16'd0, key_data},  {16'd0, e.word});
        check({name, " ascii"}, {24'd0, key_ascii}, {24'd0, e.ascii});
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic drain(input string name);
        while (sb.size() > 0) pop_check(name);
        @(negedge clk);
        check({name, " empty"}, {31'd0, key_valid}, 32'd0);
    endtask

    logic [7:0] fill_codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    logic [7:0] fill_ascii [9] = '{8'h71, 8'h77, 8'h65, 8'h72, 8'h74, 8'h79, 8'h75, 8'h69, 8'h6F};

    initial begin
        // basic press/release
        add(8'h1C, 1, 16'h001C, 8'h61, 0);
        add(8'hF0, 0, 16'h0000, 8'h00, 0);
        add(8'h1C, 1, 16'h801C, 8'h61, 1);
        // shifted letter
        add(8'h12, 1, 16'h2012, 8'h00, 0);
        add(8'h1C, 1, 16'h201C, 8'h41, 0);
        add(8'hF0, 0, 16'h0000, 8'h00, 0);
        add(8'h1C, 1, 16'hA01C, 8'h41, 0);
        add(8'hF0, 0, 16'h0000, 8'h00, 0);
        add(8'h12, 1, 16'h8012, 8'h00, 1);
        // extended keys and fake shifts
        add(8'hE0, 0, 16'h0000, 8'h00, 0);
        add(8'h75, 1, 16'h4075, 8'h00, 0);
        add(8'hE0, 0, 16'h0000, 8'h00, 0);
        add(8'hF0, 0, 16'h0000, 8'h00, 0);
        add(8'h75, 1, 16'hC075, 8'h00, 0);
        add(8'hE0, 0, 16'h0000, 8'h00, 0);
        add(8'h12, 0, 16'h0000, 8'h00, 0);
        add(8'hE0, 0, 16'h0000, 8'h00, 0);
        add(8'hF0, 0, 16'h0000, 8'h00, 0);
        add(8'h12, 0, 16'h0000, 8'h00, 1);
        // caps lock with typematic repeat, then toggle it back off
        add(8'h58, 1, 16'h0858, 8'h00, 0);
        add(8'h58, 1, 16'h0858, 8'h00, 0);
        add(8'hF0, 0, 16'h0000, 8'h00, 0);
        add(8'h58, 1, 16'h8858, 8'h00, 0);
        add(8'h1C, 1, 16'h081C, 8'h41, 0);
        add(8'h58, 1, 16'h0058, 8'h00, 0);
        add(8'hF0, 0, 16'h0000, 8'h00, 0);
        add(8'h58, 1, 16'h8058, 8'h00, 1);
        // ctrl (left and right) and a control letter
        add(8'h14, 1, 16'h1014, 8'h00, 0);
        add(8'h1C, 1, 16'h101C, 8'h01, 0);
        add(8'hF0, 0, 16'h0000, 8'h00, 0);
        add(8'h14, 1, 16'h8014, 8'h00, 0);
        add(8'hE0, 0, 16'h0000, 8'h00, 0);
        add(8'h14, 1, 16'h5014, 8'h00, 0);
        add(8'hE0, 0, 16'h0000, 8'h00, 0);
        add(8'hF0, 0, 16'h0000, 8'h00, 0);
        add(8'h14, 1, 16'hC014, 8'h00, 1);
        // digits, shifted digit via right shift, specials
        add(8'h59, 1, 16'h2059, 8'h00, 0);
        add(8'h16, 1, 16'h2016, 8'h21, 0);
        add(8'hF0, 0, 16'h0000, 8'h00, 0);
        add(8'h59, 1, 16'h8059, 8'h00, 0);
        add(8'h45, 1, 16'h0045, 8'h30, 0);
        add(8'h29, 1, 16'h0029, 8'h20, 0);
        add(8'h5A, 1, 16'h005A, 8'h0D, 1);
        // ignored codes and pause sequence
        add(8'hAA, 0, 16'h0000, 8'h00, 0);
        add(8'hFA, 0, 16'h0000, 8'h00, 0);
        add(8'hE1, 0, 16'h0000, 8'h00, 0);
        add(8'h14, 0, 16'h0000, 8'h00, 0);
        add(8'h77, 0, 16'h0000, 8'h00, 0);
        add(8'hE1, 0, 16'h0000, 8'h00, 0);
        add(8'hF0, 0, 16'h0000, 8'h00, 0);
        add(8'h14, 0, 16'h0000, 8'h00, 0);
        add(8'hF0, 0, 16'h0000, 8'h00, 0);
        add(8'h77, 0, 16'h0000, 8'h00, 0);
        add(8'h1C, 1, 16'h001C, 8'h61, 1);

        repeat (3) @(negedge clk);
        check("reset valid",    {31'd0, key_valid}, 32'd0);
        check("reset data",     {16'd0, key_data},  32'd0);
        check("reset ascii",    {24'd0, key_ascii}, 32'd0);
        check("reset overflow", {31'd0, overflow},  32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            send_byte(vecs[i].code);
            if (vecs[i].push) expect_event(vecs[i].word, vecs[i].ascii);
            if (vecs[i].drain) drain($sformatf("vec%0d", i));
        end

        // Overflow: nine presses, ninth dropped
        for (int i = 0; i < 9; i++) begin
            send_byte(fill_codes[i]);
            if (i < 8) expect_event({8'h00, fill_codes[i]}, fill_ascii[i]);
        end
        check("ovf set", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("ovf clr", {31'd0, overflow}, 32'd0);

        // Push and pop together while full: nothing dropped
        @(negedge clk);
        check("full head", {16'd0, key_data}, {16'd0, sb[0].word});
        void'(sb.pop_front());
        scan_code   = 8'h4D;
        scan_strobe = 1'b1;
        key_ack     = 1'b1;
        expect_event(16'h004D, 8'h70);
        @(negedge clk);
        key_ack = 1'b0;
        @(negedge clk);
        scan_strobe = 1'b0;
        @(negedge clk);
        check("pushpop no drop", {31'd0, overflow}, 32'd1 - 32'd1);
        drain("full pushpop");

        // Drop coincident with overflow_clr: overflow stays set, contents kept
        for (int i = 0; i < 8; i++) begin
            send_byte(fill_codes[i]);
            expect_event({8'h00, fill_codes[i]}, fill_ascii[i]);
        end
        @(negedge clk);
        scan_code    = 8'h44;
        scan_strobe  = 1'b1;
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        @(negedge clk);
        scan_strobe = 1'b0;
        check("ovf clr vs drop", {31'd0, overflow}, 32'd1);
        drain("after drop");

        // Reset after an E0 prefix clears state and queue
        send_byte(8'h2D);
        send_byte(8'hE0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset valid",    {31'd0, key_valid}, 32'd0);
        check("midreset overflow", {31'd0, overflow},  32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h1C);
        expect_event(16'h001C, 8'h61);
        drain("post reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual running required finished");
        $fatal(1);
    end

endmodule
